// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the fetch stage and its IF/ID register.
// Contents:
//   RESET_PC_DEFAULT         default PC loaded at reset
//   NOP_INSTR                bubble instruction word (sll $0,$0,0)
//   RS_MSB/RS_LSB/RT_MSB/RT_LSB  register-field slice positions
//   fetch_state_e            fetch FSM states {FS_BOOT, FS_RUN}
//   align_pc / sat_inc32     helper functions
package pipeline_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    typedef enum logic [0:0] {
        FS_BOOT = 1'b0,
        FS_RUN  = 1'b1
    } fetch_state_e;

    // Word-align a redirect target; the low two bits never reach the PC.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] val);
        if (val == 32'hFFFF_FFFF) begin
            return val;
        end else begin
            return val + 32'd1;
        end
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   load                capture instr_in / pc_plus4_in as a valid entry
//   bubble              capture a bubble (wins over load)
//   instr_in            fetched instruction word
//   pc_plus4_in         PC+4 of the fetched word
//   instruction         latched instruction
//   pc_plus4            latched PC+4
//   valid               0 = bubble
//   rs, rt              register fields sliced from the latched instruction
// With neither load nor bubble the register holds all fields.
module if_id_reg
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_plus4_in,
    output logic [31:0] instruction,
    output logic [31:0] pc_plus4,
    output logic        valid,
    output logic [4:0]  rs,
    output logic [4:0]  rt
);

    logic [31:0] instr_r;
    logic [31:0] pc_plus4_r;
    logic        valid_r;

    // IF/ID storage: bubble, load or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_r    <= NOP_INSTR;
            pc_plus4_r <= 32'h0000_0000;
            valid_r    <= 1'b0;
        end else if (bubble) begin
            instr_r    <= NOP_INSTR;
            pc_plus4_r <= 32'h0000_0000;
            valid_r    <= 1'b0;
        end else if (load) begin
            instr_r    <= instr_in;
            pc_plus4_r <= pc_plus4_in;
            valid_r    <= 1'b1;
        end else begin
            instr_r    <= instr_r;
            pc_plus4_r <= pc_plus4_r;
            valid_r    <= valid_r;
        end
    end

    assign instruction = instr_r;
    assign pc_plus4    = pc_plus4_r;
    assign valid       = valid_r;
    // Pure slices: a bubble holds NOP_INSTR, so both read as 0 then.
    assign rs          = instr_r[RS_MSB:RS_LSB];
    assign rt          = instr_r[RT_MSB:RT_LSB];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction-memory
// address and feeds the IF/ID register.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   PCWrite, stall      hazard-unit hold controls
//   IF_Flush            squash the instruction entering IF/ID
//   Jump_Hazard/Target  jump redirect resolved in ID
//   Branch_Hazard/Target taken-branch redirect resolved in EX
//   imem_addr           instruction-memory address (= PC)
//   imem_rdata          instruction word, combinational read
//   IF_ID_*             latched instruction, PC+4, valid, Rs, Rt
// Optional build macro FETCH_PERF_EN adds perf_stall_cnt / perf_flush_cnt,
// saturating counters of hold cycles and redirect/flush cycles.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          BOOT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCWrite,
    input  logic        stall,
    input  logic        IF_Flush,
    input  logic        Jump_Hazard,
    input  logic [31:0] Jump_Target,
    input  logic        Branch_Hazard,
    input  logic [31:0] Branch_Target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PC_plus4,
    output logic        IF_ID_Valid,
    output logic [4:0]  IF_ID_Rs,
    output logic [4:0]  IF_ID_Rt
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    fetch_state_e state_r, state_s;
    logic [3:0]   boot_cnt_r, boot_cnt_s;
    logic [31:0]  pc_r, pc_s;
    logic [31:0]  pc_plus4_s;
    logic         ifid_load_s;
    logic         ifid_bubble_s;
    logic         prio_stall_s;
    logic         prio_flush_s;

    assign pc_plus4_s = pc_r + 32'd4;
    assign imem_addr  = pc_r;

    // Boot sequencing and RUN-mode priority decode.
    always_comb begin
        state_s       = state_r;
        boot_cnt_s    = boot_cnt_r;
        pc_s          = pc_r;
        ifid_load_s   = 1'b0;
        ifid_bubble_s = 1'b0;
        prio_stall_s  = 1'b0;
        prio_flush_s  = 1'b0;
        case (state_r)
            FS_BOOT: begin
                // IMEM warm-up: hazards ignored, PC parked, bubbles only.
                ifid_bubble_s = 1'b1;
                boot_cnt_s    = boot_cnt_r + 4'd1;
                if (boot_cnt_r == BOOT_LAST) begin
                    state_s = FS_RUN;
                end else begin
                    state_s = FS_BOOT;
                end
            end
            FS_RUN: begin
                if (Branch_Hazard) begin
                    // The branch is older than any load-use pair, so it beats a hold.
                    pc_s          = align_pc(Branch_Target);
                    ifid_bubble_s = 1'b1;
                    prio_flush_s  = 1'b1;
                end else if (!PCWrite || stall) begin
                    // Hold everything; a jr waiting on a load re-resolves afterwards.
                    pc_s         = pc_r;
                    prio_stall_s = 1'b1;
                end else if (Jump_Hazard || IF_Flush) begin
                    if (Jump_Hazard) begin
                        pc_s = align_pc(Jump_Target);
                    end else begin
                        pc_s = pc_plus4_s;
                    end
                    ifid_bubble_s = 1'b1;
                    prio_flush_s  = 1'b1;
                end else begin
                    pc_s        = pc_plus4_s;
                    ifid_load_s = 1'b1;
                end
            end
            default: begin
                state_s       = FS_BOOT;
                ifid_bubble_s = 1'b1;
            end
        endcase
    end

    // PC, FSM state and boot counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r       <= RESET_PC;
            state_r    <= FS_BOOT;
            boot_cnt_r <= 4'd0;
        end else begin
            pc_r       <= pc_s;
            state_r    <= state_s;
            boot_cnt_r <= boot_cnt_s;
        end
    end

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .rst_n       (reset),
        .load        (ifid_load_s),
        .bubble      (ifid_bubble_s),
        .instr_in    (imem_rdata),
        .pc_plus4_in (pc_plus4_s),
        .instruction (IF_ID_Instruction),
        .pc_plus4    (IF_ID_PC_plus4),
        .valid       (IF_ID_Valid),
        .rs          (IF_ID_Rs),
        .rt          (IF_ID_Rt)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cnt_r;
    logic [31:0] perf_flush_cnt_r;

    // Saturating hold / redirect cycle counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cnt_r <= 32'h0000_0000;
            perf_flush_cnt_r <= 32'h0000_0000;
        end else begin
            if (prio_stall_s) begin
                perf_stall_cnt_r <= sat_inc32(perf_stall_cnt_r);
            end else begin
                perf_stall_cnt_r <= perf_stall_cnt_r;
            end
            if (prio_flush_s) begin
                perf_flush_cnt_r <= sat_inc32(perf_flush_cnt_r);
            end else begin
                perf_flush_cnt_r <= perf_flush_cnt_r;
            end
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_r;
    assign perf_flush_cnt = perf_flush_cnt_r;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a behavioural model predicts the state
// after each clock edge, pushes it into a queue, and the entry is popped and
// compared against the DUT once the edge has passed.
module tb_fetch_stage;

    localparam logic [31:0] TB_RESET_PC    = 32'h0040_0000;
    localparam int          TB_BOOT_CYCLES = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCWrite, stall, IF_Flush, Jump_Hazard, Branch_Hazard;
    logic [31:0] Jump_Target, Branch_Target;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] IF_ID_Instruction, IF_ID_PC_plus4;
    logic        IF_ID_Valid;
    logic [4:0]  IF_ID_Rs, IF_ID_Rt;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    // Instruction memory: a scrambled function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch_stage #(.RESET_PC(TB_RESET_PC), .BOOT_CYCLES(TB_BOOT_CYCLES)) dut (
        .clk(clk), .reset(reset), .PCWrite(PCWrite), .stall(stall),
        .IF_Flush(IF_Flush), .Jump_Hazard(Jump_Hazard), .Jump_Target(Jump_Target),
        .Branch_Hazard(Branch_Hazard), .Branch_Target(Branch_Target),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_PC_plus4(IF_ID_PC_plus4),
        .IF_ID_Valid(IF_ID_Valid), .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt)
`ifdef FETCH_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] stall_cnt;
        logic [31:0] flush_cnt;
    } exp_t;

    exp_t sb_q[$];

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state.
    logic [31:0] m_pc, m_instr, m_pc4, m_stall, m_flush;
    logic        m_valid, m_run;
    int          m_cnt;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = TB_RESET_PC; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        m_run = 1'b0; m_cnt = 0; m_stall = 32'h0; m_flush = 32'h0;
    endtask

    task automatic model_bubble();
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    endtask

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Direct check of the live outputs against the model (used around reset).
    task automatic check_now(input string tag);
        check_value({tag, "_addr"},  imem_addr, m_pc);
        check_value({tag, "_instr"}, IF_ID_Instruction, m_instr);
        check_value({tag, "_pc4"},   IF_ID_PC_plus4, m_pc4);
        check_value({tag, "_valid"}, {31'd0, IF_ID_Valid}, {31'd0, m_valid});
        check_value({tag, "_rs"},    {27'd0, IF_ID_Rs}, 32'd0);
        check_value({tag, "_rt"},    {27'd0, IF_ID_Rt}, 32'd0);
`ifdef FETCH_PERF_EN
        check_value({tag, "_pstall"}, perf_stall_cnt, 32'd0);
        check_value({tag, "_pflush"}, perf_flush_cnt, 32'd0);
`endif
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_value({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_value({tag, "_addr"},  imem_addr, e.pc);
            check_value({tag, "_instr"}, IF_ID_Instruction, e.instr);
            check_value({tag, "_pc4"},   IF_ID_PC_plus4, e.pc4);
            check_value({tag, "_valid"}, {31'd0, IF_ID_Valid}, {31'd0, e.valid});
            check_value({tag, "_rs"},    {27'd0, IF_ID_Rs}, {27'd0, e.instr[25:21]});
            check_value({tag, "_rt"},    {27'd0, IF_ID_Rt}, {27'd0, e.instr[20:16]});
`ifdef FETCH_PERF_EN
            check_value({tag, "_pstall"}, perf_stall_cnt, e.stall_cnt);
            check_value({tag, "_pflush"}, perf_flush_cnt, e.flush_cnt);
`endif
        end
    endtask

    // Drive one cycle of hazard inputs, predict the post-edge state, then compare.
    task automatic step(input string tag, input logic br, input logic [31:0] bt,
                        input logic pw, input logic st, input logic fl,
                        input logic jh, input logic [31:0] jt);
        exp_t e;
        Branch_Hazard = br; Branch_Target = bt; PCWrite = pw; stall = st;
        IF_Flush = fl; Jump_Hazard = jh; Jump_Target = jt;
        if (!m_run) begin
            model_bubble();
            if (m_cnt == TB_BOOT_CYCLES - 1) m_run = 1'b1;
            m_cnt++;
        end else if (br) begin
            m_pc = {bt[31:2], 2'b00}; model_bubble(); m_flush = sat(m_flush);
        end else if (!pw || st) begin
            m_stall = sat(m_stall);
        end else if (jh || fl) begin
            m_pc = jh ? {jt[31:2], 2'b00} : m_pc + 32'd4;
            model_bubble(); m_flush = sat(m_flush);
        end else begin
            m_instr = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
        end
        e = '{pc: m_pc, instr: m_instr, pc4: m_pc4, valid: m_valid,
              stall_cnt: m_stall, flush_cnt: m_flush};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    task automatic normal(input string tag);
        step(tag, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        reset = 1'b0; PCWrite = 1'b1; stall = 1'b0; IF_Flush = 1'b0;
        Jump_Hazard = 1'b0; Jump_Target = 32'h0;
        Branch_Hazard = 1'b0; Branch_Target = 32'h0;
        model_reset();
        #12;
        check_now("por");
        @(posedge clk); #1;
        reset = 1'b1;

        // Boot: hazards asserted but must be ignored.
        step("boot0", 1'b1, 32'h0000_1000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step("boot1", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_2000);
        for (int i = 0; i < 4; i++) normal("fetch");

        // Held jump: retained through the stall, taken on release.
        step("hold0", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0040_0200);
        step("hold1", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0040_0200);
        step("jrel",  1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0040_0200);
        normal("postj0");
        normal("postj1");

        // Branch overrides a concurrent stall.
        step("brst", 1'b1, 32'h0040_0100, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        normal("postb");
        step("flush", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);

        // PC wrap at the top of the address space (target low bits dropped).
        step("jtop", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
        normal("wrap");
        normal("postwrap");

        // Random hazard mix.
        for (int i = 0; i < 60; i++) begin
            step("rand",
                 ($urandom_range(0, 7) == 0), $urandom(),
                 ($urandom_range(0, 5) != 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                 $urandom());
        end

        // Park at 0x00400040 and reset mid-cycle.
        step("j40", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0043);
        normal("pre_rst");
        step("j40b", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0043);
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        check_now("midrst");
        @(posedge clk); #1;
        reset = 1'b1;
        step("reboot0", 1'b1, 32'h0000_3000, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_4000);
        step("reboot1", 1'b1, 32'h0000_3000, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_4000);
        normal("rerun0");
        normal("rerun1");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register: owns the PC, drives the instruction-memory address, and latches the fetched instruction for ID.
- It is the consumer of the hazard unit's PCWrite / stall / IF_Flush signals and of the Jump_Hazard / Branch_Hazard redirects.
- It returns IF_ID_Rs / IF_ID_Rt to the hazard unit, closing the load-use detection loop.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded at reset.
- BOOT_CYCLES, 2, cycles after reset release before the first fetch is latched (IMEM warm-up); legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- PCWrite  in  1  1 = PC may update this cycle.
- stall  in  1  1 = hold IF/ID (load-use).
- IF_Flush  in  1  1 = squash the instruction entering IF/ID.
- Jump_Hazard  in  1  jump resolved in ID this cycle.
- Jump_Target  in  32  jump destination.
- Branch_Hazard  in  1  taken branch resolved in EX this cycle.
- Branch_Target  in  32  branch destination.
- imem_addr  out  32  instruction-memory address (= PC, combinational).
- imem_rdata  in  32  instruction word; combinational read, valid in the same cycle.
- IF_ID_Instruction  out  32  latched instruction.
- IF_ID_PC_plus4  out  32  latched PC+4.
- IF_ID_Valid  out  1  0 = bubble.
- IF_ID_Rs  out  5  IF_ID_Instruction[25:21].
- IF_ID_Rt  out  5  IF_ID_Instruction[20:16].

Behaviour:
- Reset (async, reset=0):
  - PC=RESET_PC.
  - IF_ID_Instruction=0, IF_ID_PC_plus4=0, IF_ID_Valid=0.
  - Boot counter=0, state=BOOT.
  - Reset mid-operation discards all in-flight state immediately.
- State machine:
  - BOOT: PC holds at RESET_PC; IF/ID is loaded with a bubble every cycle; the counter increments.
  - BOOT -> RUN when the counter reaches BOOT_CYCLES-1.
  - All hazard inputs are ignored in BOOT.
  - RUN persists until reset.
- RUN per-cycle priority (highest first):
  1. Branch_Hazard=1: PC<=Branch_Target; IF/ID<=bubble. This overrides stall/PCWrite; the branch is older than any load-use pair.
  2. PCWrite=0 or stall=1: PC holds, IF/ID holds (all fields). IF_Flush/Jump_Hazard are ignored this cycle, so a jr in ID waiting on a load is retained and re-resolves after the stall.
  3. Jump_Hazard=1 or IF_Flush=1: PC<=Jump_Target when Jump_Hazard=1, otherwise PC<=PC+4. IF/ID<=bubble.
  4. Normal: PC<=PC+4; IF_ID_Instruction<=imem_rdata; IF_ID_PC_plus4<=PC+4; IF_ID_Valid<=1.
- Bubble encoding: Instruction=32'h0000_0000 (sll nop), PC_plus4=0, Valid=0.
- Arithmetic:
  - PC+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0 silently.
  - Targets are used as given; bits [1:0] are forced to 0 when loaded into PC.
- Latency:
  - A fetched word appears on IF_ID_* one clock after its address is on imem_addr.
  - A redirect takes effect on imem_addr the cycle after the hazard input is asserted.
- IF_ID_Rs/Rt are pure slices of the register (no extra delay); they are 0 during a bubble.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0], both reset to 0.
  - stall_cnt increments on each RUN cycle taking priority 2.
  - flush_cnt increments on each RUN cycle taking priority 1 or 3.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package pipeline_pkg holds:
  - RESET_PC default.
  - NOP_INSTR = 32'h0.
  - Field slice constants RS_MSB/RS_LSB/RT_MSB/RT_LSB.
  - Fetch-state enum {FS_BOOT, FS_RUN}.
- One natural sub-module: if_id_reg. It holds the IF/ID register, with load/hold/bubble control inputs and the Rs/Rt slices.
- fetch_stage keeps the PC, the boot FSM, priority decode and the optional counters.

Test Plan:
- Reset release with BOOT_CYCLES=2 -> imem_addr=0x00400000 for 2 cycles with IF_ID_Valid=0; the 3rd edge latches imem_rdata with PC_plus4=0x00400004 and Valid=1.
- Steady fetch of 3 words -> imem_addr 0x00400000/04/08 on consecutive cycles; IF_ID_Rs/Rt match instruction bits.
- stall=1, PCWrite=0 for 2 cycles with Jump_Hazard=1, IF_Flush=1 -> PC and IF/ID unchanged; after release with the jump still asserted, PC<=Jump_Target and IF/ID is a bubble.
- Branch_Hazard=1 with Branch_Target=0x00400100 together with stall=1 -> next PC=0x00400100, IF_ID_Valid=0.
- PC=0xFFFFFFFC, no hazards -> next PC=0x00000000, PC_plus4 latched as 0.
- Reset asserted mid-run at PC=0x00400040 -> outputs cleared asynchronously (before the next edge), state=BOOT. With FETCH_PERF_EN defined, the counters read 0.
